// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// FSM states and the default frame start marker.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader.
// The loader is the slave; the byte source and imem sit on the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: keeps the first three bytes of a word
// and flags the fourth so the caller can register the whole word.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [23:0] word_q;
    logic [1:0]  cnt_q;

    assign word_o       = {word_q, byte_i};
    assign word_ready_o = en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            word_q <= {word_q[15:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame-driven imem loader: syncs on a marker byte, writes big-endian words
// to sequential addresses and releases the CPU once the checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int          CW  = ADDR_W + 1;
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_e            state_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;
    logic [15:0]       len_q;
    logic [CW-1:0]     word_cnt_q;
    logic [7:0]        acc_q;

    logic          accept;
    logic          is_sync;
    logic          restart;
    logic          pack_en;
    logic          word_ready;
    logic [31:0]   packed_word;
    logic [15:0]   len_full;
    logic [CW-1:0] word_cnt_d;
    logic          last_word;

    assign accept   = bus.in_valid && in_ready_q;
    assign is_sync  = (bus.in_data == SYNC_BYTE);
    assign restart  = accept && is_sync &&
                      (state_q == S_IDLE || state_q == S_DONE ||
                       state_q == S_ERROR);
    assign pack_en  = accept && (state_q == S_DATA);
    assign len_full = {len_q[15:8], bus.in_data};

    assign word_cnt_d = word_cnt_q + CW'(1);
    assign last_word  = (16'(word_cnt_d) == len_q);

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .rst_n_i     (reset),
        .clr_i       (restart),
        .en_i        (pack_en),
        .byte_i      (bus.in_data),
        .word_o      (packed_word),
        .word_ready_o(word_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (is_sync) begin
                            state_q    <= S_LEN_HI;
                            word_cnt_q <= '0;
                            acc_q      <= '0;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            hold_q     <= 1'b1;
                        end
                    end
                    S_LEN_HI: begin
                        len_q[15:8] <= bus.in_data;
                        state_q     <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q[7:0] <= bus.in_data;
                        if ({1'b0, len_full} > CAP) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        acc_q <= acc_q ^ bus.in_data;
                        if (word_ready) begin
                            we_q       <= 1'b1;
                            addr_q     <= word_cnt_q[ADDR_W-1:0];
                            wdata_q    <= packed_word;
                            word_cnt_q <= word_cnt_d;
                            if (last_word) state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (bus.in_data == acc_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame table plus reset corner sequences,
// with a write scoreboard fed by the frame generator.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold, done, err;

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader #(.ADDR_W(6), .SYNC_BYTE(8'hA5)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          garbage;
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[9];
    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [31:0] word_of(int i, logic [31:0] w0,
                                            logic [31:0] w1);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return w0 ^ (32'(i) * 32'h01030507);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(logic [7:0] b, bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(vec_t v);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        if (v.garbage) begin
            send_byte(8'h00, 1'b0);
            send_byte(8'hFF, 1'b0);
            send_byte(8'h13, 1'b0);
        end
        send_byte(8'hA5, v.gaps);
        send_byte(v.len[15:8], v.gaps);
        send_byte(v.len[7:0], v.gaps);
        if (v.len <= 16'd64) begin
            for (int i = 0; i < int'(v.len); i++) begin
                w = word_of(i, v.w0, v.w1);
                exp_q.push_back('{6'(i), w});
                for (int k = 3; k >= 0; k--) begin
                    cs ^= w[8*k +: 8];
                    send_byte(w[8*k +: 8], v.gaps);
                end
            end
            send_byte(cs ^ v.flip, v.gaps);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_after(string tag, bit ed, bit ee);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".err"}, 32'(err), 32'(ee));
        chk({tag, ".hold"}, 32'(cpu_hold), 32'(!ed));
        chk({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 16'd2, 32'h20080005, 32'hAC080000, 8'h00, 0, 1, 0};
        vecs[1] = '{0, 16'd2, 32'h20080005, 32'hAC080000, 8'h01, 0, 0, 1};
        vecs[2] = '{0, 16'd2, 32'h20080005, 32'hAC080000, 8'h00, 0, 1, 0};
        vecs[3] = '{0, 16'h41, 32'h0, 32'h0, 8'h00, 0, 0, 1};
        vecs[4] = '{0, 16'h40, 32'h12345678, 32'hA5A5A5A5, 8'h00, 0, 1, 0};
        vecs[5] = '{1, 16'd0, 32'h0, 32'h0, 8'h00, 0, 1, 0};
        vecs[6] = '{0, 16'd0, 32'h0, 32'h0, 8'h01, 0, 0, 1};
        vecs[7] = '{0, 16'd2, 32'h20080005, 32'hAC080000, 8'h00, 1, 1, 0};
        vecs[8] = '{0, 16'd1, 32'hA50000A5, 32'h0, 8'h00, 0, 1, 0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;

        fork
            forever begin
                wr_t e;
                @(negedge clk);
                if (bus.mem_we === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_write: addr %h data %h",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("waddr", 32'(bus.mem_addr), 32'(e.addr));
                        chk("wdata", bus.mem_wdata, e.data);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.hold", 32'(cpu_hold), 32'd1);
        chk("rst.we", 32'(bus.mem_we), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.wdata", bus.mem_wdata, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("run.in_ready", 32'(bus.in_ready), 32'd1);
        chk("run.hold", 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i]);
            check_after($sformatf("vec%0d", i), vecs[i].exp_done,
                        vecs[i].exp_err);
            if (vecs[i].len == 16'h40)
                chk("last_addr", 32'(bus.mem_addr), 32'd63);
        end

        // reset arrives after six payload bytes of a two-word frame
        @(posedge clk); #1;
        exp_q.push_back('{6'd0, 32'h20080005});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hAC, 1'b0);
        send_byte(8'h08, 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid.hold", 32'(cpu_hold), 32'd1);
        chk("mid.in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid.done", 32'(done), 32'd0);
        chk("mid.addr", 32'(bus.mem_addr), 32'd0);
        chk("mid.pending", 32'(exp_q.size()), 32'd0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(vecs[0]);
        check_after("post_rst", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
